// File: rtl/spi_ram_arbiter.sv
// Arbiter sharing one synchronous RAM port between the CPU and the SPI loader.
// Define SPI_ARB_STARVE_GUARD_EN to stop the CPU from starving SPI while loading=0.
module spi_ram_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  loading,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic                  cpu_ack,
    output logic [7:0]            cpu_rdata,
    input  logic                  spi_req,
    input  logic                  spi_we,
    input  logic [ADDR_WIDTH-1:0] spi_addr,
    input  logic [7:0]            spi_wdata,
    output logic                  spi_ack,
    output logic [7:0]            spi_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_din,
    input  logic [7:0]            ram_dout,
    output logic                  cpu_wait_n
);

    // state     | meaning
    // IDLE      | arbitrate between pending requests
    // CPU_ISSUE | CPU operands on the RAM port
    // CPU_ACK   | CPU read data valid, cpu_ack high
    // SPI_ISSUE | SPI operands on the RAM port
    // SPI_ACK   | SPI read data valid, spi_ack high
    typedef enum logic [2:0] {
        IDLE,
        CPU_ISSUE,
        CPU_ACK,
        SPI_ISSUE,
        SPI_ACK
    } state_t;

    state_t state;
    logic   cpu_ok;
    logic   spi_win;
    logic   cpu_win;
    logic   starve_hit;

    assign cpu_ok = cpu_req && !loading;

`ifdef SPI_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Counts CPU grants that passed over a waiting SPI request.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (spi_win || !spi_req) begin
                starve_cnt <= '0;
            end else if (cpu_win && !starve_hit) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT == 0);
    assign starve_hit          = 1'b0;
`endif

    assign spi_win = spi_req && (loading || starve_hit || !cpu_ok);
    assign cpu_win = cpu_ok && !spi_win;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            cpu_ack  <= 1'b0;
            spi_ack  <= 1'b0;
        end else begin
            ram_we  <= 1'b0;
            cpu_ack <= 1'b0;
            spi_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (spi_win) begin
                        state    <= SPI_ISSUE;
                        ram_we   <= spi_we;
                        ram_addr <= spi_addr;
                        ram_din  <= spi_wdata;
                    end else if (cpu_win) begin
                        state    <= CPU_ISSUE;
                        ram_we   <= cpu_we;
                        ram_addr <= cpu_addr;
                        ram_din  <= cpu_wdata;
                    end
                end
                CPU_ISSUE: begin
                    state   <= CPU_ACK;
                    cpu_ack <= 1'b1;
                end
                CPU_ACK:   state <= IDLE;
                SPI_ISSUE: begin
                    state   <= SPI_ACK;
                    spi_ack <= 1'b1;
                end
                SPI_ACK:   state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // RAM output is only meaningful while the matching ack is high.
    assign cpu_rdata = ram_dout;
    assign spi_rdata = ram_dout;

    assign cpu_wait_n = !(loading ||
                          (cpu_req && (state == IDLE || state == CPU_ISSUE ||
                                       state == SPI_ISSUE || state == SPI_ACK)));

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter; honours SPI_ARB_STARVE_GUARD_EN like the design.
module tb_spi_ram_arbiter;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        loading;
    logic        cpu_req, cpu_we, spi_req, spi_we;
    logic [15:0] cpu_addr, spi_addr;
    logic [7:0]  cpu_wdata, spi_wdata;
    logic        cpu_ack, spi_ack, ram_we, cpu_wait_n;
    logic [7:0]  cpu_rdata, spi_rdata, ram_din;
    logic [15:0] ram_addr;
    logic [7:0]  ram_dout = 8'h00;
    logic [7:0]  mem [0:65535] = '{default: 8'h00};

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int we_cycles = 0;
    int wait_bad = 0;

    typedef struct {
        logic       is_spi;
        logic       chk_d;
        logic [7:0] rdata;
        int         at_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    spi_ram_arbiter #(.ADDR_WIDTH(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .n_reset(n_reset), .loading(loading),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_ack(spi_ack), .spi_rdata(spi_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .cpu_wait_n(cpu_wait_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void expect_ack(logic is_spi, logic chk_d, logic [7:0] d, int at);
        exp_t e;
        e.is_spi = is_spi;
        e.chk_d  = chk_d;
        e.rdata  = d;
        e.at_cyc = at;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (ram_we) we_cycles++;
        if (loading && cpu_wait_n) wait_bad++;
        if (cpu_ack || spi_ack) begin
            if (cpu_ack && spi_ack) check("ack_overlap", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {30'd0, cpu_ack, spi_ack}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_owner", {31'd0, spi_ack}, {31'd0, mon_e.is_spi});
                check("ack_cycle", cyc, mon_e.at_cyc);
                if (mon_e.chk_d)
                    check("ack_rdata", spi_ack ? spi_rdata : cpu_rdata, mon_e.rdata);
            end
        end
    end

    task automatic cpu_start(logic we, logic [15:0] a, logic [7:0] d);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    endtask

    task automatic spi_start(logic we, logic [15:0] a, logic [7:0] d);
        spi_we = we; spi_addr = a; spi_wdata = d; spi_req = 1'b1;
    endtask

    task automatic wait_cpu_ack();
        int n = 0;
        while (!cpu_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cpu_ack_seen", {31'd0, cpu_ack}, 32'd1);
        check("cpu_wait_n_at_ack", {31'd0, cpu_wait_n}, 32'd1);
        cpu_req = 1'b0;
    endtask

    task automatic wait_spi_ack();
        int n = 0;
        while (!spi_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("spi_ack_seen", {31'd0, spi_ack}, 32'd1);
        spi_req = 1'b0;
    endtask

    task automatic cpu_access(logic we, logic [15:0] a, logic [7:0] d, logic chk, logic [7:0] exp_d);
        @(negedge clk);
        expect_ack(1'b0, chk, exp_d, cyc + 2);
        cpu_start(we, a, d);
        #1;
        check("cpu_wait_n_idle_req", {31'd0, cpu_wait_n}, 32'd0);
        wait_cpu_ack();
    endtask

    task automatic spi_access(logic we, logic [15:0] a, logic [7:0] d, logic chk, logic [7:0] exp_d);
        @(negedge clk);
        expect_ack(1'b1, chk, exp_d, cyc + 2);
        spi_start(we, a, d);
        wait_spi_ack();
    endtask

    initial begin
        int we0;
        int n0;
        n_reset = 1'b0; loading = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        spi_req = 1'b0; spi_we = 1'b0; spi_addr = '0; spi_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", {5'd0, ram_we, ram_addr, ram_din, cpu_ack, spi_ack}, 32'd0);
        n_reset = 1'b1;
        @(negedge clk);
        check("idle_outs", {5'd0, ram_we, ram_addr, ram_din, cpu_ack, spi_ack}, 32'd0);
        check("idle_wait_n", {31'd0, cpu_wait_n}, 32'd1);

        // CPU write then read back
        cpu_access(1'b1, 16'h4000, 8'hA5, 1'b0, 8'h00);
        cpu_access(1'b0, 16'h4000, 8'h00, 1'b1, 8'hA5);

        // Loader owns memory: CPU read held pending, SPI write served
        @(negedge clk);
        loading = 1'b1;
        cpu_start(1'b0, 16'h1234, 8'h00);
        we0 = we_cycles;
        wait_bad = 0;
        spi_access(1'b1, 16'h1234, 8'h3C, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        check("load_we_cycles", we_cycles - we0, 32'd1);
        check("load_wait_n_low", wait_bad, 32'd0);
        check("load_mem", mem[16'h1234], 8'h3C);
        loading = 1'b0;
        expect_ack(1'b0, 1'b1, 8'h3C, cyc + 2);
        wait_cpu_ack();

        // Simultaneous requests with CPU priority
        @(negedge clk);
        expect_ack(1'b0, 1'b0, 8'h00, cyc + 2);
        expect_ack(1'b1, 1'b0, 8'h00, cyc + 5);
        cpu_start(1'b1, 16'h0010, 8'h11);
        spi_start(1'b1, 16'h0020, 8'h22);
        fork
            wait_cpu_ack();
            wait_spi_ack();
        join
        cpu_access(1'b0, 16'h0020, 8'h00, 1'b1, 8'h22);
        spi_access(1'b0, 16'h0010, 8'h00, 1'b1, 8'h11);

        // Reset during CPU_ISSUE of a write
        @(negedge clk);
        cpu_start(1'b1, 16'h0055, 8'h77);
        @(negedge clk);
        check("issue_we", {31'd0, ram_we}, 32'd1);
        n_reset = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("abort_we", {31'd0, ram_we}, 32'd0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("post_reset_outs", {5'd0, ram_we, ram_addr, ram_din, cpu_ack, spi_ack}, 32'd0);
        check("aborted_mem", mem[16'h0055], 8'h00);
        cpu_access(1'b0, 16'h0055, 8'h00, 1'b1, 8'h00);

        // Continuous CPU and SPI requests with loading low
        @(negedge clk);
        n0 = cyc;
`ifdef SPI_ARB_STARVE_GUARD_EN
        for (int k = 0; k < 4; k++) expect_ack(1'b0, 1'b1, 8'hA5, n0 + 2 + 3 * k);
        expect_ack(1'b1, 1'b1, 8'h3C, n0 + 14);
`else
        for (int k = 0; k < 5; k++) expect_ack(1'b0, 1'b1, 8'hA5, n0 + 2 + 3 * k);
`endif
        cpu_start(1'b0, 16'h4000, 8'h00);
        spi_start(1'b0, 16'h1234, 8'h00);
        repeat (14) @(negedge clk);
        cpu_req = 1'b0;
        spi_req = 1'b0;
        repeat (2) @(negedge clk);
        check("starve_pending", exp_q.size(), 32'd0);

        // Top-of-range address
        cpu_access(1'b1, 16'hFFFF, 8'h5A, 1'b0, 8'h00);
        spi_access(1'b0, 16'hFFFF, 8'h00, 1'b1, 8'h5A);

        repeat (3) @(negedge clk);
        check("leftover_expect", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
